hdlc_core: RTL and testbench

Receive-side HDLC controller behind an 8-bit register bus. It takes a serial bit stream and detects flags and aborts. It removes stuffed zeros, optionally checks the CRC-16 FCS, and stores frame bytes in a 128-byte buffer that a host reads through memory-mapped registers. The transmit channel is a separate block; its register addresses read as zero here.

---
 rtl/hdlc_pkg.sv | 56 +++++
 rtl/hdlc_if.sv | 31 +++
 rtl/hdlc_rx_channel.sv | 125 ++++++++++++
 rtl/hdlc_core.sv | 138 +++++++++++++
 tb/tb_hdlc_core.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/hdlc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hdlc_pkg
// Purpose  : Shared constants for the HDLC receive controller: register
//            addresses, Rx_SC bit positions, buffer sizing, CRC polynomial,
//            framing-state encoding and the byte-wise CRC-16 helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package hdlc_pkg;

  // Register map
  localparam logic [2:0] c_ADDR_TX0     = 3'd0;
  localparam logic [2:0] c_ADDR_TX1     = 3'd1;
  localparam logic [2:0] c_ADDR_RX_SC   = 3'd2;
  localparam logic [2:0] c_ADDR_RX_BUFF = 3'd3;
  localparam logic [2:0] c_ADDR_RX_LEN  = 3'd4;

  // Rx_SC bit positions
  localparam int c_SC_READY = 0;
  localparam int c_SC_DROP  = 1;
  localparam int c_SC_FERR  = 2;
  localparam int c_SC_ABORT = 3;
  localparam int c_SC_OVF   = 4;
  localparam int c_SC_FCSEN = 5;

  // Buffer and FCS sizing
  localparam logic [7:0] c_BUF_DEPTH = 8'd128;
  localparam logic [7:0] c_FCS_LEN   = 8'd2;

  // CRC-16 generator x^16+x^15+x^2+1 in normal form; the datapath uses the
  // bit-reversed form because bytes arrive LSB first.
  localparam logic [15:0] c_CRC_POLY = 16'h8005;

  // Framing-state encoding
  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_HUNT = 2'd1;
  localparam logic [1:0] c_ST_DATA = 2'd2;
  localparam logic [1:0] c_ST_END  = 2'd3;

  // Advance a reflected CRC-16 by one byte, bit 0 first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc,
                                             input logic [7:0]  data);
    logic [15:0] poly_r;
    logic [15:0] c;
    for (int i = 0; i < 16; i++) poly_r[i] = c_CRC_POLY[15-i];
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ poly_r;
      else                c = c >> 1;
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hdlc_if.sv
`default_nettype none
// ============================================================================
// Module   : hdlc_if
// Purpose  : Host register bus plus serial receive line of the HDLC core.
// Ports    : Address[2:0], WriteEnable, ReadEnable, DataIn[7:0] (host->core)
//            DataOut[7:0], Rx_Ready (core->host)
//            Rx, RxEN (line->core)
//            master = host/line side, slave = core side.
// Revision : 1.0 - initial release
// ============================================================================
interface hdlc_if;
  logic [2:0] Address;
  logic       WriteEnable;
  logic       ReadEnable;
  logic [7:0] DataIn;
  logic [7:0] DataOut;
  logic       Rx;
  logic       RxEN;
  logic       Rx_Ready;

  modport master (
    output Address, WriteEnable, ReadEnable, DataIn, Rx, RxEN,
    input  DataOut, Rx_Ready
  );

  modport slave (
    input  Address, WriteEnable, ReadEnable, DataIn, Rx, RxEN,
    output DataOut, Rx_Ready
  );
endinterface
`default_nettype wire

// File: rtl/hdlc_rx_channel.sv
`default_nettype none
// ============================================================================
// Module   : hdlc_rx_channel
// Purpose  : Serial front end: ones counting for flag / abort / stuffed-zero
//            detection, de-stuffed byte assembly, framing FSM and CRC-16.
// Ports    : Clk, Rst (async, active low)
//            rx, rx_en        - serial bit and its sample enable
//            frame_start      - first byte of a new frame (pulse)
//            new_byte,rx_data - de-stuffed byte for the buffer (pulse)
//            eof              - closing flag processed (pulse)
//            misaligned       - closing flag not on a byte boundary (with eof)
//            fcs_err          - non-zero CRC residue (with eof)
//            abort            - seven ones seen inside a frame (pulse)
// Revision : 1.0 - initial release
// ============================================================================
module hdlc_rx_channel
  import hdlc_pkg::*;
(
  input  logic       Clk,
  input  logic       Rst,
  input  logic       rx,
  input  logic       rx_en,
  output logic       frame_start,
  output logic       new_byte,
  output logic [7:0] rx_data,
  output logic       eof,
  output logic       misaligned,
  output logic       fcs_err,
  output logic       abort
);

  logic [1:0]  r_state;
  logic [2:0]  r_ones;     // consecutive raw ones, saturating at 7
  logic [7:0]  r_shift;
  logic [2:0]  r_bitcnt;   // de-stuffed bits since the last byte/flag
  logic [15:0] r_crc;
  logic        r_frame_start, r_new_byte, r_eof, r_misaligned, r_fcs_err, r_abort;
  logic [7:0]  r_data;

  // A zero after exactly five ones is stuffing, after six it ends a flag;
  // a seventh one is an abort. Because the sender always stuffs, six ones
  // are always preceded by a zero, so "0 after six ones" is 01111110.
  logic       w_stuffed, w_flag, w_abort_bit, w_data_bit, w_byte_done;
  logic [7:0] w_byte;

  assign w_stuffed   = !rx && (r_ones == 3'd5);
  assign w_flag      = !rx && (r_ones == 3'd6);
  assign w_abort_bit =  rx && (r_ones == 3'd6);
  assign w_data_bit  = !w_stuffed && !w_flag;
  assign w_byte      = {rx, r_shift[7:1]};
  assign w_byte_done = w_data_bit && (r_bitcnt == 3'd7);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state       <= c_ST_IDLE;
      r_ones        <= 3'd0;
      r_shift       <= 8'd0;
      r_bitcnt      <= 3'd0;
      r_crc         <= 16'd0;
      r_frame_start <= 1'b0;
      r_new_byte    <= 1'b0;
      r_data        <= 8'd0;
      r_eof         <= 1'b0;
      r_misaligned  <= 1'b0;
      r_fcs_err     <= 1'b0;
      r_abort       <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      r_new_byte    <= 1'b0;
      r_eof         <= 1'b0;
      r_abort       <= 1'b0;

      // END lasts one cycle; no bit event can fire that soon after a flag.
      if (r_state == c_ST_END) begin
        r_eof     <= 1'b1;
        r_fcs_err <= (r_crc != 16'd0);
        r_state   <= c_ST_HUNT;
      end

      if (rx_en) begin
        r_ones <= rx ? ((r_ones == 3'd7) ? 3'd7 : r_ones + 3'd1) : 3'd0;
        if (w_data_bit) begin
          r_shift  <= w_byte;
          r_bitcnt <= r_bitcnt + 3'd1;
        end
        if (w_flag) begin
          // The flag's leading 0111111 was shifted in as seven data bits,
          // so an aligned frame leaves exactly seven pending bits here.
          r_bitcnt <= 3'd0;
          if (r_state == c_ST_DATA) begin
            r_state      <= c_ST_END;
            r_misaligned <= (r_bitcnt != 3'd7);
          end else begin
            r_state <= c_ST_HUNT;
          end
        end else if (w_abort_bit) begin
          if (r_state == c_ST_DATA) r_abort <= 1'b1;
          r_state <= c_ST_IDLE;
        end else if (w_byte_done) begin
          if (r_state == c_ST_HUNT) begin
            r_state       <= c_ST_DATA;
            r_frame_start <= 1'b1;
            r_new_byte    <= 1'b1;
            r_data        <= w_byte;
            r_crc         <= crc16_byte(16'd0, w_byte);
          end else if (r_state == c_ST_DATA) begin
            r_new_byte <= 1'b1;
            r_data     <= w_byte;
            r_crc      <= crc16_byte(r_crc, w_byte);
          end
        end
      end
    end
  end

  assign frame_start = r_frame_start;
  assign new_byte    = r_new_byte;
  assign rx_data     = r_data;
  assign eof         = r_eof;
  assign misaligned  = r_misaligned;
  assign fcs_err     = r_fcs_err;
  assign abort       = r_abort;

endmodule
`default_nettype wire

// File: rtl/hdlc_core.sv
`default_nettype none
// ============================================================================
// Module   : hdlc_core
// Purpose  : HDLC receive controller: 128-byte frame buffer, frame length,
//            status/control register and host register decode.
// Ports    : Clk - system clock, rising edge
//            Rst - asynchronous active-low reset
//            bus - hdlc_if.slave (register bus, Rx line, Rx_Ready)
// Revision : 1.0 - initial release
// ============================================================================
module hdlc_core
  import hdlc_pkg::*;
(
  input  logic Clk,
  input  logic Rst,
  hdlc_if.slave bus
);

  logic       w_frame_start, w_new_byte, w_eof, w_misaligned, w_fcs_err, w_abort;
  logic [7:0] w_rx_data;

  hdlc_rx_channel u_rx (
    .Clk         (Clk),
    .Rst         (Rst),
    .rx          (bus.Rx),
    .rx_en       (bus.RxEN),
    .frame_start (w_frame_start),
    .new_byte    (w_new_byte),
    .rx_data     (w_rx_data),
    .eof         (w_eof),
    .misaligned  (w_misaligned),
    .fcs_err     (w_fcs_err),
    .abort       (w_abort)
  );

  logic [7:0] r_buf [0:c_BUF_DEPTH-1];
  logic [7:0] r_wr_ptr;   // also the received byte count, max 128
  logic [7:0] r_rd_ptr;
  logic [7:0] r_len;
  logic       r_ready, r_ferr, r_abort, r_ovf, r_fcsen;
  logic [7:0] r_dout;

  logic       w_wr, w_drop, w_rd_buff, w_frame_err;
  logic [6:0] w_wr_addr;
  logic [7:0] w_sc;

  // frame_start arrives together with the first byte, which goes to slot 0.
  assign w_wr      = w_new_byte && (w_frame_start || (r_wr_ptr != c_BUF_DEPTH));
  assign w_wr_addr = w_frame_start ? 7'd0 : r_wr_ptr[6:0];
  assign w_drop    = bus.WriteEnable && (bus.Address == c_ADDR_RX_SC) &&
                     bus.DataIn[c_SC_DROP];
  assign w_rd_buff = bus.ReadEnable && (bus.Address == c_ADDR_RX_BUFF) &&
                     (r_rd_ptr < r_len);
  assign w_frame_err = w_misaligned || (r_wr_ptr == 8'd0) ||
                       (r_fcsen && ((r_wr_ptr < c_FCS_LEN + 8'd1) || w_fcs_err));

  always_comb begin
    w_sc             = 8'd0;
    w_sc[c_SC_READY] = r_ready;
    w_sc[c_SC_FERR]  = r_ferr;
    w_sc[c_SC_ABORT] = r_abort;
    w_sc[c_SC_OVF]   = r_ovf;
    w_sc[c_SC_FCSEN] = r_fcsen;
  end

  always_ff @(posedge Clk) begin
    if (w_wr) r_buf[w_wr_addr] <= w_rx_data;
  end

  // Later assignments take priority: frame start beats drop and reads.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_wr_ptr <= 8'd0;
      r_rd_ptr <= 8'd0;
      r_len    <= 8'd0;
      r_ready  <= 1'b0;
      r_ferr   <= 1'b0;
      r_abort  <= 1'b0;
      r_ovf    <= 1'b0;
      r_fcsen  <= 1'b0;
      r_dout   <= 8'd0;
    end else begin
      if (w_new_byte && !w_frame_start) begin
        if (r_wr_ptr == c_BUF_DEPTH) r_ovf    <= 1'b1;
        else                         r_wr_ptr <= r_wr_ptr + 8'd1;
      end

      if (w_abort) r_abort <= 1'b1;

      if (w_eof) begin
        r_ferr   <= w_frame_err;
        r_ready  <= !w_frame_err;
        r_rd_ptr <= 8'd0;
        if (w_frame_err) r_len <= 8'd0;
        else             r_len <= r_fcsen ? (r_wr_ptr - c_FCS_LEN) : r_wr_ptr;
      end

      if (bus.WriteEnable && (bus.Address == c_ADDR_RX_SC))
        r_fcsen <= bus.DataIn[c_SC_FCSEN];

      if (bus.ReadEnable) begin
        case (bus.Address)
          c_ADDR_TX0, c_ADDR_TX1: r_dout <= 8'd0;
          c_ADDR_RX_SC:           r_dout <= w_sc;
          c_ADDR_RX_BUFF:         r_dout <= w_rd_buff ? r_buf[r_rd_ptr[6:0]] : 8'd0;
          c_ADDR_RX_LEN:          r_dout <= r_len;
          default:                r_dout <= 8'd0;
        endcase
      end

      if (w_rd_buff) begin
        r_rd_ptr <= r_rd_ptr + 8'd1;
        if (r_rd_ptr + 8'd1 == r_len) r_ready <= 1'b0;
      end

      if (w_drop) begin
        r_ready  <= 1'b0;
        r_len    <= 8'd0;
        r_rd_ptr <= 8'd0;
      end

      if (w_frame_start) begin
        r_wr_ptr <= 8'd1;
        r_rd_ptr <= 8'd0;
        r_len    <= 8'd0;
        r_ready  <= 1'b0;
        r_ferr   <= 1'b0;
        r_abort  <= 1'b0;
        r_ovf    <= 1'b0;
      end
    end
  end

  assign bus.DataOut  = r_dout;
  assign bus.Rx_Ready = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_hdlc_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_hdlc_core
// Purpose  : Directed self-checking bench for hdlc_core: plain frame, FCS
//            good/bad, bit stuffing, abort, overflow, drop, reset mid-frame.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_hdlc_core;
  import hdlc_pkg::*;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   tb_ones;

  hdlc_if bus ();

  hdlc_core dut (
    .Clk (clk),
    .Rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got,
                          input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference CRC-16 (x^16+x^15+x^2+1, reflected, init 0), bit 0 first.
  function automatic logic [15:0] ref_crc(input logic [15:0] crc,
                                          input logic [7:0]  d);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 16'hA001;
      else             c = c >> 1;
    end
    return c;
  endfunction

  task automatic send_raw(input logic b);
    @(negedge clk);
    bus.Rx   = b;
    bus.RxEN = 1'b1;
  endtask

  task automatic send_flag();
    logic [7:0] f;
    f = 8'h7E;
    for (int i = 0; i < 8; i++) send_raw(f[i]);
    tb_ones = 0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    for (int i = 0; i < 8; i++) begin
      send_raw(d[i]);
      if (d[i]) begin
        tb_ones++;
        if (tb_ones == 5) begin
          send_raw(1'b0);
          tb_ones = 0;
        end
      end else begin
        tb_ones = 0;
      end
    end
  endtask

  task automatic send_abort();
    for (int i = 0; i < 7; i++) send_raw(1'b1);
    tb_ones = 0;
  endtask

  task automatic rx_idle();
    @(negedge clk);
    bus.RxEN = 1'b0;
    bus.Rx   = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic host_read(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.Address    = a;
    bus.ReadEnable = 1'b1;
    @(negedge clk);
    bus.ReadEnable = 1'b0;
    d = bus.DataOut;
  endtask

  task automatic host_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.Address     = a;
    bus.DataIn      = d;
    bus.WriteEnable = 1'b1;
    @(negedge clk);
    bus.WriteEnable = 1'b0;
  endtask

  initial begin
    logic [7:0]  rd;
    logic [7:0]  fb [10];
    logic [15:0] crc;

    n_tests = 0;
    n_fail  = 0;
    tb_ones = 0;
    bus.Address = 3'd0; bus.WriteEnable = 1'b0; bus.ReadEnable = 1'b0;
    bus.DataIn = 8'd0; bus.Rx = 1'b1; bus.RxEN = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check_eq("rst_dout", bus.DataOut, 16'h00);
    check_eq("rst_ready", bus.Rx_Ready, 16'h0);
    host_read(c_ADDR_RX_SC, rd);  check_eq("rst_sc", rd, 16'h00);
    host_read(c_ADDR_RX_LEN, rd); check_eq("rst_len", rd, 16'h00);

    // Plain frame 12 34 56, FCS off
    send_flag(); send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_flag();
    rx_idle();
    check_eq("f1_ready_port", bus.Rx_Ready, 16'h1);
    host_read(c_ADDR_RX_SC, rd);   check_eq("f1_sc", rd, 16'h01);
    host_read(c_ADDR_RX_LEN, rd);  check_eq("f1_len", rd, 16'h03);
    host_read(c_ADDR_TX0, rd);     check_eq("f1_tx0", rd, 16'h00);
    host_read(c_ADDR_RX_BUFF, rd); check_eq("f1_b0", rd, 16'h12);
    host_read(c_ADDR_RX_BUFF, rd); check_eq("f1_b1", rd, 16'h34);
    host_read(c_ADDR_RX_BUFF, rd); check_eq("f1_b2", rd, 16'h56);
    check_eq("f1_ready_after", bus.Rx_Ready, 16'h0);
    host_read(c_ADDR_RX_BUFF, rd); check_eq("f1_beyond", rd, 16'h00);

    // FCS on: 10 bytes plus correct CRC, then with one flipped FCS bit
    host_write(c_ADDR_RX_SC, 8'h20);
    crc = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      fb[i] = 8'h10 + 8'(i * 19);
      crc = ref_crc(crc, fb[i]);
    end
    for (int pass = 0; pass < 2; pass++) begin
      logic [15:0] fcs;
      fcs = (pass == 0) ? crc : (crc ^ 16'h0001);
      send_flag();
      for (int i = 0; i < 10; i++) send_byte(fb[i]);
      send_byte(fcs[7:0]); send_byte(fcs[15:8]);
      send_flag();
      rx_idle();
      if (pass == 0) begin
        host_read(c_ADDR_RX_SC, rd);   check_eq("fcs_ok_sc", rd, 16'h21);
        host_read(c_ADDR_RX_LEN, rd);  check_eq("fcs_ok_len", rd, 16'h0A);
        host_read(c_ADDR_RX_BUFF, rd); check_eq("fcs_ok_b0", rd, {8'h00, fb[0]});
      end else begin
        host_read(c_ADDR_RX_SC, rd);   check_eq("fcs_bad_sc", rd, 16'h24);
        check_eq("fcs_bad_ready", bus.Rx_Ready, 16'h0);
      end
    end
    host_write(c_ADDR_RX_SC, 8'h00);

    // Stuffing: 0xFF goes out as 111110111
    send_flag(); send_byte(8'hFF); send_flag();
    rx_idle();
    host_read(c_ADDR_RX_LEN, rd);  check_eq("stuff_len", rd, 16'h01);
    host_read(c_ADDR_RX_BUFF, rd); check_eq("stuff_b0", rd, 16'hFF);

    // Abort mid-frame, then a valid frame clears the abort status
    send_flag(); send_byte(8'h12); send_abort();
    rx_idle();
    host_read(c_ADDR_RX_SC, rd); check_eq("abort_sc", rd, 16'h08);
    check_eq("abort_ready", bus.Rx_Ready, 16'h0);
    send_flag(); send_byte(8'hA5); send_flag();
    rx_idle();
    host_read(c_ADDR_RX_SC, rd);   check_eq("post_abort_sc", rd, 16'h01);
    host_read(c_ADDR_RX_BUFF, rd); check_eq("post_abort_b0", rd, 16'hA5);

    // Overflow: 130 bytes
    send_flag();
    for (int i = 0; i < 130; i++) send_byte(8'(i + 7));
    send_flag();
    rx_idle();
    host_read(c_ADDR_RX_SC, rd);   check_eq("ovf_sc", rd, 16'h11);
    host_read(c_ADDR_RX_LEN, rd);  check_eq("ovf_len", rd, 16'h80);
    host_read(c_ADDR_RX_BUFF, rd); check_eq("ovf_b0", rd, 16'h07);
    host_read(c_ADDR_RX_BUFF, rd); check_eq("ovf_b1", rd, 16'h08);

    // Drop
    host_write(c_ADDR_RX_SC, 8'h02);
    @(negedge clk);
    check_eq("drop_ready", bus.Rx_Ready, 16'h0);
    host_read(c_ADDR_RX_SC, rd); check_eq("drop_sc", rd, 16'h10);

    // Reset in the middle of a frame
    host_write(c_ADDR_RX_SC, 8'h20);
    send_flag(); send_byte(8'h3C); send_raw(1'b1); send_raw(1'b0); send_raw(1'b1);
    @(negedge clk);
    bus.RxEN = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_ready", bus.Rx_Ready, 16'h0);
    host_read(c_ADDR_RX_SC, rd);   check_eq("mid_rst_sc", rd, 16'h00);
    host_read(c_ADDR_RX_LEN, rd);  check_eq("mid_rst_len", rd, 16'h00);
    host_read(c_ADDR_RX_BUFF, rd); check_eq("mid_rst_buff", rd, 16'h00);
    host_read(c_ADDR_TX1, rd);     check_eq("mid_rst_tx1", rd, 16'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
